// File: rtl/ct_spsram_pkg.sv
// Shared types and constants for the parametrised shadow-tainted SRAM wrapper.
//   - state_e   : initialisation FSM states
//   - depth_of  : number of words for a given address width
//   - CEN_ON / GWEN_WR / WEN_WR : active-low control encodings
package ct_spsram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic CEN_ON  = 1'b0;  // chip selected
  localparam logic GWEN_WR = 1'b0;  // write cycle (1 = read)
  localparam logic WEN_WR  = 1'b0;  // bit is written

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ct_spsram_param_core.sv
// Plain bit-masked single-port array with a one-cycle registered read.
// Used twice by the wrapper: once for data, once for the taint shadow.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset of the read register
//   we       : write strobe
//   re       : read strobe (read register holds when low)
//   addr     : word address
//   wmask_n  : per-bit write enable, active-low
//   wdata    : write data
//   rdata    : registered read data
module ct_spsram_param_core
  import ct_spsram_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 144
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wmask_n,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(AW);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata_p0;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= (r_mem[addr] & wmask_n) | (wdata & ~wmask_n);
  end

  always_ff @(posedge clk) begin
    if (rst)     r_rdata_p0 <= '0;
    else if (re) r_rdata_p0 <= r_mem[addr];
  end

  assign rdata = r_rdata_p0;

endmodule

// File: rtl/ct_spsram_param_memshade.sv
// Parametrised single-port SRAM wrapper with a taint shadow array.
// After reset an init sweep zeroes both arrays (DEPTH cycles), then the
// wrapper serves one access per cycle. Taint flows from data, write mask,
// address and control taint; an address-taint sticky flag poisons every
// later read until reset.
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   A / A_t0           : address and its taint
//   CEN / CEN_t0       : chip enable (active-low) and taint
//   GWEN / GWEN_t0     : global write enable (active-low) and taint
//   WEN / WEN_t0       : per-bit write enable (active-low) and taint
//   D / D_t0           : write data and taint
//   Q / Q_t0           : read data and taint
//   INIT_DONE          : high once the init sweep has finished
module ct_spsram_param_memshade
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  INIT_DONE
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic                  r_sticky_t;
  logic                  r_rdterm_p0;

  logic                  w_init;
  logic                  w_ready;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_t_wr;
  logic [DATA_WIDTH-1:0] w_ctl_t;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_q_p0;
  logic [DATA_WIDTH-1:0] w_qt_raw_p0;
  logic [DATA_WIDTH-1:0] w_qt_p0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Nothing touches the arrays on a reset edge.
  assign w_init  = (r_state == ST_INIT)  & ~RST;
  assign w_ready = (r_state == ST_READY) & ~RST;

  assign w_wr = w_ready & (CEN == CEN_ON) & (GWEN == GWEN_WR);
  assign w_rd = w_ready & (CEN == CEN_ON) & (GWEN != GWEN_WR);

  // A write is possible whenever each control is either asserted or tainted.
  // If the write is only possible (not certain) the control taint is set, so
  // w_ctl_t is all-ones and every bit is forced tainted.
  assign w_t_wr  = w_ready & ((CEN == CEN_ON) | CEN_t0) & ((GWEN == GWEN_WR) | GWEN_t0);
  assign w_ctl_t = WEN_t0 | {DATA_WIDTH{CEN_t0 | GWEN_t0}};
  assign w_addr  = w_init ? r_cnt : A;

  ct_spsram_param_core #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_data (
    .clk     (CLK),
    .rst     (RST),
    .we      (w_init | w_wr),
    .re      (w_rd),
    .addr    (w_addr),
    .wmask_n (w_init ? '0 : WEN),
    .wdata   (w_init ? '0 : D),
    .rdata   (w_q_p0)
  );

  ct_spsram_param_core #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_taint (
    .clk     (CLK),
    .rst     (RST),
    .we      (w_init | w_t_wr),
    .re      (w_rd),
    .addr    (w_addr),
    .wmask_n (w_init ? '0 : (WEN & ~w_ctl_t)),
    .wdata   (w_init ? '0 : (D_t0 | w_ctl_t)),
    .rdata   (w_qt_raw_p0)
  );

  always_ff @(posedge CLK) begin
    if (RST)                   r_sticky_t <= 1'b0;
    else if (w_t_wr && |A_t0)  r_sticky_t <= 1'b1;
  end

  // Whole-word taint term, captured on the read edge alongside the array read.
  always_ff @(posedge CLK) begin
    if (RST)       r_rdterm_p0 <= 1'b0;
    else if (w_rd) r_rdterm_p0 <= |A_t0 | CEN_t0 | GWEN_t0 | r_sticky_t;
  end

  assign w_qt_p0 = w_qt_raw_p0 | {DATA_WIDTH{r_rdterm_p0}};

  // ---- stage p0 -> p1 (optional output register) ----
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_q_p1;
    logic [DATA_WIDTH-1:0] r_qt_p1;
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_q_p1  <= '0;
        r_qt_p1 <= '0;
      end else begin
        r_q_p1  <= w_q_p0;
        r_qt_p1 <= w_qt_p0;
      end
    end
    assign Q    = r_q_p1;
    assign Q_t0 = r_qt_p1;
  end else begin : g_no_out_reg
    assign Q    = w_q_p0;
    assign Q_t0 = w_qt_p0;
  end

  assign INIT_DONE = r_init_done;

endmodule

// File: tb/tb_ct_spsram_param_memshade.sv
module tb_ct_spsram_param_memshade;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] A, A_t0;
  logic          CEN, CEN_t0, GWEN, GWEN_t0;
  logic [DW-1:0] WEN, WEN_t0, D, D_t0;
  logic [DW-1:0] Q0, Q0_t0, Q1, Q1_t0;
  logic          DONE0, DONE1;

  int nchk  = 0;
  int npass = 0;

  always #5 CLK = ~CLK;

  ct_spsram_param_memshade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) dut0 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q0), .Q_t0(Q0_t0), .INIT_DONE(DONE0)
  );

  ct_spsram_param_memshade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q1), .Q_t0(Q1_t0), .INIT_DONE(DONE1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    A = '0; A_t0 = '0; CEN = 1'b1; CEN_t0 = 1'b0; GWEN = 1'b1; GWEN_t0 = 1'b0;
    WEN = '1; WEN_t0 = '0; D = '0; D_t0 = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    A = a; D = d; WEN = wen; CEN = 1'b0; GWEN = 1'b0;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    A = a; CEN = 1'b0; GWEN = 1'b1;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    RST = 1'b1;
    cyc();
    chk("rst_done", {15'd0, DONE0}, 16'h0000);
    chk("rst_q", Q0, 16'h0000);
    chk("rst_qt", Q0_t0, 16'h0000);
    RST = 1'b0;

    // Init sweep: 16 cycles, with a user write to addr 3 that must be dropped.
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) begin
        A = 4'd3; D = 16'hFFFF; WEN = '0; CEN = 1'b0; GWEN = 1'b0;
      end
      if (k == 6) idle();
      cyc();
      chk($sformatf("init_done_%0d", k), {15'd0, DONE0}, 16'(k == 16));
    end

    for (int a = 0; a < 16; a++) begin
      rd(AW'(a));
      chk($sformatf("zero_q_%0d", a), Q0, 16'h0000);
      chk($sformatf("zero_qt_%0d", a), Q0_t0, 16'h0000);
    end

    // Basic write/read and latency of both output configurations.
    wr(4'd5, 16'hA5A5, 16'h0000);
    chk("no_wr_through", Q0, 16'h0000);
    rd(4'd5);
    chk("rd5_q_or0", Q0, 16'hA5A5);
    chk("rd5_q_or1_early", Q1, 16'h0000);
    cyc();
    chk("rd5_q_hold_or0", Q0, 16'hA5A5);
    chk("rd5_q_or1", Q1, 16'hA5A5);
    chk("rd5_qt_or0", Q0_t0, 16'h0000);
    chk("rd5_qt_or1", Q1_t0, 16'h0000);
    cyc();
    chk("rd5_q_hold2", Q0, 16'hA5A5);

    // Bit mask on data and taint.
    D_t0 = 16'hFFFF;
    wr(4'd6, 16'hFFFF, 16'hFF00);
    rd(4'd6);
    chk("mask_q", Q0, 16'h00FF);
    chk("mask_qt", Q0_t0, 16'h00FF);

    // Tainted write-mask bit on a non-written bit.
    wr(4'd7, 16'hFFFF, 16'h0000);
    WEN_t0 = 16'h0001;
    wr(4'd7, 16'h0000, 16'hFFFF);
    rd(4'd7);
    chk("wen_t_q", Q0, 16'hFFFF);
    chk("wen_t_qt", Q0_t0, 16'h0001);

    // Tainted chip enable on a read poisons only that read.
    CEN_t0 = 1'b1;
    rd(4'd5);
    chk("cen_t_rd_q", Q0, 16'hA5A5);
    chk("cen_t_rd_qt", Q0_t0, 16'hFFFF);
    rd(4'd5);
    chk("clean_rd_qt", Q0_t0, 16'h0000);

    // Deselected but tainted CEN with GWEN=write: taint-only write.
    A = 4'd8; CEN = 1'b1; CEN_t0 = 1'b1; GWEN = 1'b0;
    cyc();
    idle();
    chk("cen_t_idle_hold", Q0, 16'hA5A5);
    rd(4'd8);
    chk("cen_t_wr_q", Q0, 16'h0000);
    chk("cen_t_wr_qt", Q0_t0, 16'hFFFF);

    // Deselected, untainted CEN: tainted GWEN must not write taint.
    A = 4'd9; CEN = 1'b1; GWEN = 1'b0; GWEN_t0 = 1'b1;
    cyc();
    idle();
    rd(4'd9);
    chk("gwen_t_gated_qt", Q0_t0, 16'h0000);

    // Address taint on a write sets the sticky flag.
    A_t0 = 4'h1;
    wr(4'd2, 16'h1234, 16'h0000);
    rd(4'd10);
    chk("sticky_q10", Q0, 16'h0000);
    chk("sticky_qt10", Q0_t0, 16'hFFFF);
    rd(4'd2);
    chk("sticky_q2", Q0, 16'h1234);
    chk("sticky_qt2", Q0_t0, 16'hFFFF);

    // Reset, then reset again at init cycle 7; sweep restarts.
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst2_q", Q0, 16'h0000);
    chk("rst2_qt", Q0_t0, 16'h0000);
    for (int k = 1; k <= 7; k++) cyc();
    chk("mid_done", {15'd0, DONE0}, 16'h0000);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk($sformatf("reinit_done_%0d", k), {15'd0, DONE0}, 16'(k == 16));
    end
    chk("reinit_done_or1", {15'd0, DONE1}, 16'h0001);
    rd(4'd2);
    chk("reinit_q2", Q0, 16'h0000);
    chk("reinit_qt2", Q0_t0, 16'h0000);
    rd(4'd8);
    chk("reinit_qt8", Q0_t0, 16'h0000);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
